reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Parametrised power-on reset sequencer: holds CHANNELS reset outputs asserted for
//  HOLD_CYCLES after reset release, then deasserts them one by one, STAGE_GAP cycles apart.
//  Adds a soft-reset request that re-runs the sequence without a full system reset.
//  Sits at the top level between the board reset and the per-subsystem reset inputs.
// PARAMETERS
//  CHANNELS     4      number of reset outputs, 1..32; released in index order 0 first
//  HOLD_CYCLES  65535  cycles from sequence start to release of channel 0, >=1
//  STAGE_GAP    16     cycles between release of channel k-1 and channel k, >=1
//  CNT_W        16     counter width; must hold max(HOLD_CYCLES, STAGE_GAP)
// PORTS
//  iClock      in   1               single clock, all logic on rising edge
//  iReset      in   1               synchronous, active-high block reset
//  iSoftReset  in   1               soft-reset request, sampled each edge, level or pulse
//  oReset      out  CHANNELS        per-channel reset, active-high, registered
//  oStage      out  $clog2(CHANNELS+1)  count of channels currently released
//  oDone       out  1               high when all channels released
// BEHAVIOUR
//  - Reset: iReset=1 at an edge -> oReset={CHANNELS{1}}, oStage=0, oDone=0, counter=0,
//    state HOLD. iReset overrides every state and iSoftReset.
//  - HOLD: counter+1 per edge. On the edge where counter reaches HOLD_CYCLES: clear
//    oReset[0], oStage=1, counter=0, go STAGE (or RUN if CHANNELS=1, oDone=1 same edge).
//    So oReset[0] falls exactly HOLD_CYCLES edges after the last edge with iReset=1.
//  - STAGE: counter+1 per edge. On reaching STAGE_GAP: clear oReset[oStage], oStage+1,
//    counter=0. Releasing the last channel -> RUN, oDone=1 on that same edge.
//  - RUN: outputs static; counter held at 0.
//  - iSoftReset=1 in HOLD, STAGE or RUN: see CONFIGURATION for reassert behaviour.
//    In HOLD it restarts the hold count (counter=0).
//  - oReset bits are only ever cleared in index order; oStage == number of zero bits.
//  - Counter never wraps: compared against the terminal value, cleared on match.
//  - All outputs are flops; no combinational path from any input to any output.
// CONFIGURATION
//  Macro RESET_SEQ_ORDERED_ASSERT_EN.
//  - Undefined: iSoftReset=1 at edge S -> oReset all 1s, oStage=0, oDone=0, counter=0,
//    state HOLD at S. Channel 0 releases at S+HOLD_CYCLES.
//  - Defined: iSoftReset in STAGE/RUN enters state ASSERT: at edge S the highest
//    released channel re-asserts, oDone=0. Then one more channel re-asserts every
//    STAGE_GAP edges, in descending index order. When channel 0 re-asserts,
//    oStage=0, counter=0, go HOLD.
//    Soft reset in HOLD behaves as undefined case. iSoftReset ignored during ASSERT.
//    iReset still asserts all channels on the same edge.
// TESTING  (CHANNELS=4, HOLD_CYCLES=8, STAGE_GAP=3; edge 1 = first edge with iReset=0)
//  - Power-up: iReset 1->0 -> oReset=F until edge 7; 4'hE@8, C@11, 8@14, 0@17.
//    oStage 1,2,3,4 on those edges; oDone=1 @17.
//  - Reset mid-sequence: iReset=1 at edge 12 -> oReset=F, oStage=0, oDone=0 at 12.
//    With iReset low from edge 13, channel 0 releases at 12+8=20.
//  - Soft reset in RUN (macro off): iSoftReset pulse @S -> oReset=F, oDone=0 @S.
//    Release sequence 4'hE@S+8, then C, 8, 0 at 3-edge spacing.
//  - Soft reset in HOLD: iSoftReset @5 -> oReset stays F; oReset[0] falls @13, not @8.
//  - Macro on, soft @S in RUN -> oReset 8@S, C@S+3, E@S+6, F@S+9.
//    Then E@S+17. A second iSoftReset @S+4 has no effect.
//  - CHANNELS=1, HOLD_CYCLES=1: oReset=0 and oDone=1 at edge 1. iReset held high ->
//    oReset stays 1 indefinitely.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer status/request bundle: soft-reset request in, per-channel resets and progress out.
// The sequencer side uses the slave modport; the consumer/controller side uses master.
interface reset_sequencer_if #(
    parameter int CHANNELS = 4
);
    localparam int STG_W = $clog2(CHANNELS + 1);

    logic                iSoftReset;
    logic [CHANNELS-1:0] oReset;
    logic [STG_W-1:0]    oStage;
    logic                oDone;

    modport master (output iSoftReset, input oReset, oStage, oDone);
    modport slave  (input iSoftReset, output oReset, oStage, oDone);
endinterface

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds all channels, then releases them in index order STAGE_GAP apart.
// Optional macro RESET_SEQ_ORDERED_ASSERT_EN makes a soft reset re-assert channels in reverse order.
module reset_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 65535,
    parameter int STAGE_GAP   = 16,
    parameter int CNT_W       = 16
) (
    input  logic             iClock,
    input  logic             iReset,
    reset_sequencer_if.slave bus
);
    localparam int STG_W = $clog2(CHANNELS + 1);
    localparam logic [CNT_W-1:0]    HOLD_T   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]    GAP_T    = CNT_W'(STAGE_GAP);
    localparam logic [STG_W-1:0]    LAST_STG = STG_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] ONE      = CHANNELS'(1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STAGE,
        ST_RUN,
        ST_ASSERT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntInc;
    logic [STG_W-1:0] stgDec;

    assign cntInc = cnt + 1'b1;
    assign stgDec = bus.oStage - 1'b1;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            bus.oReset <= '1;
            bus.oStage <= '0;
            bus.oDone  <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (bus.iSoftReset) begin
                        cnt <= '0;
                    end else if (cntInc == HOLD_T) begin
                        bus.oReset <= bus.oReset & ~ONE;
                        bus.oStage <= STG_W'(1);
                        cnt        <= '0;
                        if (CHANNELS == 1) begin
                            state     <= ST_RUN;
                            bus.oDone <= 1'b1;
                        end else begin
                            state <= ST_STAGE;
                        end
                    end else begin
                        cnt <= cntInc;
                    end
                end
                ST_STAGE, ST_RUN: begin
                    if (bus.iSoftReset) begin
                        cnt       <= '0;
                        bus.oDone <= 1'b0;
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
                        // Re-assert the highest released channel now; the rest follow in ASSERT.
                        bus.oReset <= bus.oReset | (ONE << stgDec);
                        bus.oStage <= stgDec;
                        state      <= (stgDec == '0) ? ST_HOLD : ST_ASSERT;
`else
                        bus.oReset <= '1;
                        bus.oStage <= '0;
                        state      <= ST_HOLD;
`endif
                    end else if (state == ST_STAGE) begin
                        if (cntInc == GAP_T) begin
                            bus.oReset <= bus.oReset & ~(ONE << bus.oStage);
                            bus.oStage <= bus.oStage + 1'b1;
                            cnt        <= '0;
                            if (bus.oStage == LAST_STG) begin
                                state     <= ST_RUN;
                                bus.oDone <= 1'b1;
                            end
                        end else begin
                            cnt <= cntInc;
                        end
                    end
                end
`ifdef RESET_SEQ_ORDERED_ASSERT_EN
                ST_ASSERT: begin
                    // Soft-reset requests are deliberately ignored while walking back down.
                    if (cntInc == GAP_T) begin
                        bus.oReset <= bus.oReset | (ONE << stgDec);
                        bus.oStage <= stgDec;
                        cnt        <= '0;
                        if (stgDec == '0) begin
                            state <= ST_HOLD;
                        end
                    end else begin
                        cnt <= cntInc;
                    end
                end
`endif
                default: begin
                    state      <= ST_HOLD;
                    cnt        <= '0;
                    bus.oReset <= '1;
                    bus.oStage <= '0;
                    bus.oDone  <= 1'b0;
                end
            endcase
        end
    end
endmodule
